// File: rtl/if_stage.sv
// Instruction fetch stage with PC/nPC pair, ready-handshake fetch and IF/ID register.
// Build option IF_DELAY_SLOT_EN: defined = MIPS delay slot; undefined = taken branch squashes the fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        le,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction_reg,
  output logic [31:0] pc_id,
  output logic        instr_valid,
  output logic        fetch_busy
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] npc, npc_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic [31:0] ir_nxt, pc_id_nxt;
  logic        valid_nxt;
`ifdef IF_DELAY_SLOT_EN
  logic        br_pend, br_pend_nxt;
  logic [31:0] br_tgt, br_tgt_nxt;
`endif

  // A flush moves the fetch pointer exactly as an unstalled load would.
  logic        le_eff;
  logic        got_word;
  logic [31:0] word;
  logic        advance;
  logic        take_br;

  assign le_eff   = le | flush;
  assign got_word = (state == FETCH) ? imem_ready : 1'b1;
  assign word     = (state == FETCH) ? imem_rdata : hold_buf;
  assign advance  = le_eff & got_word;
  assign take_br  = branch_taken & le_eff;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (imem_ready && !le_eff) state_nxt = HOLD;
      HOLD:  if (le_eff)                state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Outputs decoded from state and PC
  always_comb begin
    imem_req   = (state == FETCH) && !reset;
    imem_addr  = pc;
    fetch_busy = (state == FETCH) && !imem_ready;
  end

  always_comb begin
    pc_nxt       = pc;
    npc_nxt      = npc;
    hold_buf_nxt = hold_buf;
    ir_nxt       = instruction_reg;
    pc_id_nxt    = pc_id;
    valid_nxt    = instr_valid;
`ifdef IF_DELAY_SLOT_EN
    br_pend_nxt  = br_pend;
    br_tgt_nxt   = br_tgt;
`endif

    if (state == FETCH && imem_ready && !le_eff)
      hold_buf_nxt = imem_rdata;

`ifdef IF_DELAY_SLOT_EN
    if (advance) begin
      ir_nxt    = flush ? NOP_WORD : word;
      valid_nxt = !flush;
      if (!flush) pc_id_nxt = pc;
      pc_nxt      = npc;
      npc_nxt     = take_br ? branch_target : (br_pend ? br_tgt : npc + 32'd4);
      br_pend_nxt = 1'b0;
    end else begin
      if (le_eff) begin
        ir_nxt    = NOP_WORD;
        valid_nxt = 1'b0;
      end
      if (take_br) begin
        br_pend_nxt = 1'b1;
        br_tgt_nxt  = branch_target;
      end
    end
`else
    // Without a delay slot the in-flight word (or held word) is squashed.
    if (take_br) begin
      pc_nxt    = branch_target;
      npc_nxt   = branch_target + 32'd4;
      ir_nxt    = NOP_WORD;
      valid_nxt = 1'b0;
    end else if (advance) begin
      ir_nxt    = flush ? NOP_WORD : word;
      valid_nxt = !flush;
      if (!flush) pc_id_nxt = pc;
      pc_nxt  = npc;
      npc_nxt = npc + 32'd4;
    end else if (le_eff) begin
      ir_nxt    = NOP_WORD;
      valid_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= RESET_PC;
      npc             <= RESET_PC + 32'd4;
      hold_buf        <= NOP_WORD;
      instruction_reg <= NOP_WORD;
      pc_id           <= 32'h0000_0000;
      instr_valid     <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
      br_pend         <= 1'b0;
      br_tgt          <= 32'h0000_0000;
`endif
    end else begin
      pc              <= pc_nxt;
      npc             <= npc_nxt;
      hold_buf        <= hold_buf_nxt;
      instruction_reg <= ir_nxt;
      pc_id           <= pc_id_nxt;
      instr_valid     <= valid_nxt;
`ifdef IF_DELAY_SLOT_EN
      br_pend         <= br_pend_nxt;
      br_tgt          <= br_tgt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns address + 0x100 with no wait states unless imem_ready is dropped.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, le, flush, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata, imem_addr, instruction_reg, pc_id;
  logic        imem_req, instr_valid, fetch_busy;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h100;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .le              (le),
    .flush           (flush),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .instruction_reg (instruction_reg),
    .pc_id           (pc_id),
    .instr_valid     (instr_valid),
    .fetch_busy      (fetch_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; le = 1'b1; flush = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b1;

    step();
    check("rst_req",   {31'b0, imem_req},    32'h0);
    check("rst_ir",    instruction_reg,      32'h0);
    check("rst_vld",   {31'b0, instr_valid}, 32'h0);
    check("rst_pcid",  pc_id,                32'h0);
    check("rst_addr",  imem_addr,            32'h0);
    reset = 1'b0;
    #1;
    check("first_req",  {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr,         32'h0);

    step();
    check("seq0_ir",   instruction_reg,      32'h100);
    check("seq0_pc",   pc_id,                32'h0);
    check("seq0_vld",  {31'b0, instr_valid}, 32'h1);
    step();
    check("seq1_ir",   instruction_reg,      32'h104);
    check("seq1_pc",   pc_id,                32'h4);

    le = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",  pc_id,             32'h4);
      check("stall_ir",  instruction_reg,   32'h104);
      check("stall_req", {31'b0, imem_req}, 32'h0);
    end
    le = 1'b1;
    step();
    check("unhold_pc",   pc_id,             32'h8);
    check("unhold_ir",   instruction_reg,   32'h108);
    check("unhold_req",  {31'b0, imem_req}, 32'h1);
    check("unhold_addr", imem_addr,         32'hC);
    step();
    check("seq3_pc",   pc_id,           32'hC);
    check("seq3_ir",   instruction_reg, 32'h10C);

    imem_ready = 1'b0;
    #1;
    check("busy", {31'b0, fetch_busy}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("bub_vld",  {31'b0, instr_valid}, 32'h0);
      check("bub_ir",   instruction_reg,      32'h0);
      check("bub_addr", imem_addr,            32'h10);
    end
    imem_ready = 1'b1;
    #1;
    check("notbusy", {31'b0, fetch_busy}, 32'h0);

`ifdef IF_DELAY_SLOT_EN
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    check("ds_pc0", pc_id, 32'h10);
    branch_taken = 1'b0;
    step();
    check("ds_pc1", pc_id, 32'h14);
    step();
    check("ds_pc2", pc_id,           32'h40);
    check("ds_ir2", instruction_reg, 32'h140);

    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    step();
    check("pend_vld",  {31'b0, instr_valid}, 32'h0);
    check("pend_addr", imem_addr,            32'h44);
    imem_ready = 1'b1; branch_taken = 1'b0;
    step();
    check("pend_pc0", pc_id, 32'h44);
    step();
    check("pend_pc1", pc_id, 32'h48);
    step();
    check("pend_pc2", pc_id, 32'h80);
`else
    step();
    check("nds_pc0", pc_id,           32'h10);
    check("nds_ir0", instruction_reg, 32'h110);
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    check("nds_nop_vld", {31'b0, instr_valid}, 32'h0);
    check("nds_nop_ir",  instruction_reg,      32'h0);
    check("nds_addr",    imem_addr,            32'h40);
    branch_taken = 1'b0;
    step();
    check("nds_pc2", pc_id,                32'h40);
    check("nds_ir2", instruction_reg,      32'h140);
    check("nds_vld", {31'b0, instr_valid}, 32'h1);

    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    step();
    check("nds_wbr_vld",  {31'b0, instr_valid}, 32'h0);
    check("nds_wbr_addr", imem_addr,            32'h80);
    imem_ready = 1'b1; branch_taken = 1'b0;
    step();
    check("nds_wbr_pc", pc_id, 32'h80);
`endif

    flush = 1'b1;
    step();
    check("fl_vld",  {31'b0, instr_valid}, 32'h0);
    check("fl_ir",   instruction_reg,      32'h0);
    check("fl_pcid", pc_id,                32'h80);
    check("fl_addr", imem_addr,            32'h88);
    flush = 1'b0;
    step();
    check("postfl_pc", pc_id,           32'h88);
    check("postfl_ir", instruction_reg, 32'h188);

    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
`ifdef IF_DELAY_SLOT_EN
    step();
    check("wrap_ds_pc", pc_id, 32'h8C);
    branch_taken = 1'b0;
    step();
    check("wrap_ds_pc1", pc_id, 32'h90);
`else
    step();
    branch_taken = 1'b0;
`endif
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc",    pc_id,           32'hFFFF_FFFC);
    check("wrap_ir",    instruction_reg, 32'h0000_00FC);
    check("wrap_addr1", imem_addr,       32'h0);

    le = 1'b0;
    step();
    check("mid_hold_req", {31'b0, imem_req}, 32'h0);
    reset = 1'b1;
    step();
    check("mrst_vld",  {31'b0, instr_valid}, 32'h0);
    check("mrst_pcid", pc_id,                32'h0);
    check("mrst_addr", imem_addr,            32'h0);
    check("mrst_req",  {31'b0, imem_req},    32'h0);
    reset = 1'b0; le = 1'b1;
    #1;
    check("mrst_req1", {31'b0, imem_req}, 32'h1);
    step();
    check("mrst_pc", pc_id,           32'h0);
    check("mrst_ir", instruction_reg, 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
